// File: rtl/kasumi_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t        : responder FSM states (IDLE, READ, RESP)
//   src_t          : where a read's data comes from (SRAM, nothing, timer registers)
//   MTIME*_ADDR    : byte addresses of the machine-timer registers
//   MTIMECMP_RESET : reset value of mtimecmp (all ones, so no interrupt after reset)
package kasumi_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_SRAM        = 3'd0,
        SRC_NONE        = 3'd1,
        SRC_MTIME_LO    = 3'd2,
        SRC_MTIME_HI    = 3'd3,
        SRC_MTIMECMP_LO = 3'd4,
        SRC_MTIMECMP_HI = 3'd5
    } src_t;

    localparam logic [31:0] MTIME_LO_ADDR    = 32'hFFFF_FF00;
    localparam logic [31:0] MTIME_HI_ADDR    = 32'hFFFF_FF04;
    localparam logic [31:0] MTIMECMP_LO_ADDR = 32'hFFFF_FF08;
    localparam logic [31:0] MTIMECMP_HI_ADDR = 32'hFFFF_FF0C;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word-granular address match; the byte-offset bits never take part.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM, one-cycle read latency, no reset.
//   clk   : clock, rising edge
//   en    : port enable; with we=0 performs a read, with we=1 a write
//   we    : write enable (write takes priority over read on the same access)
//   addr  : word address
//   wdata : full write word
//   rdata : read word, valid the cycle after a read access; held otherwise
module dmem_sram #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM stage: whole-word reads and writes served
// from an internal SRAM. Reads take IDLE -> READ (stall) -> RESP; writes
// commit at acceptance with no stall. Out-of-range accesses read zero, drop
// writes and pulse err for one cycle.
// Optional feature macro: KASUMI_DMEM_TIMER_EN builds a memory-mapped machine
// timer (mtime/mtimecmp at 32'hFFFF_FF00..0C) and drives timer_irq.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : request present
//   req_write : 1 = write, 0 = read
//   req_addr  : byte address, bits [1:0] ignored
//   req_wdata : full write word
//   rdata     : read data, valid while in RESP
//   stall     : high during READ; holds the pipeline and its request
//   err       : one-cycle pulse the cycle after an out-of-range acceptance
//   timer_irq : mtime >= mtimecmp as seen on the previous edge (0 without timer)
module dmem_responder
    import kasumi_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TIMER_DIV   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        timer_irq
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SRAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    // Classify an address. The 33-bit subtraction makes addresses below
    // BASE_ADDR borrow into bit 32 so they can never look in range.
    // Timer registers take priority should they overlap the SRAM window.
    function automatic src_t decode(input logic [31:0] a);
        logic [32:0] off;
        src_t        s;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        s   = SRC_NONE;
        if (!off[32] && (off < SRAM_BYTES)) begin
            s = SRC_SRAM;
        end
`ifdef KASUMI_DMEM_TIMER_EN
        if (word_match(a, MTIME_LO_ADDR))    s = SRC_MTIME_LO;
        if (word_match(a, MTIME_HI_ADDR))    s = SRC_MTIME_HI;
        if (word_match(a, MTIMECMP_LO_ADDR)) s = SRC_MTIMECMP_LO;
        if (word_match(a, MTIMECMP_HI_ADDR)) s = SRC_MTIMECMP_HI;
`endif
        return s;
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    state_t      state;
    logic [31:0] addr_p1;
    logic [31:0] sram_q;
    logic [31:0] mmio_rdata;
    logic        accept_p0;
    src_t        src_p0;
    src_t        src_p1;
    logic        sram_en;
    logic        sram_we;

    // ---- p0: request acceptance in IDLE ----
    assign accept_p0 = req_valid && (state == ST_IDLE);
    assign src_p0    = decode(req_addr);
    assign sram_en   = accept_p0 && (src_p0 == SRC_SRAM);
    assign sram_we   = sram_en && req_write;

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (word_index(req_addr)),
        .wdata (req_wdata),
        .rdata (sram_q)
    );

    // Captured read address; data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            addr_p1 <= req_addr;
        end
    end

    // ---- p1: READ cycle, source selected from the captured address ----
    assign src_p1 = decode(addr_p1);

`ifdef KASUMI_DMEM_TIMER_EN
    localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             mmio_we;
    logic             irq_r;

    assign tick    = (div_cnt == DIV_W'(TIMER_DIV - 1));
    assign mmio_we = accept_p0 && req_write;

    // A software write to an mtime half overrides the increment in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            mtime    <= 64'd0;
            mtimecmp <= MTIMECMP_RESET;
            irq_r    <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (mmio_we && (src_p0 == SRC_MTIME_LO)) begin
                mtime <= {mtime[63:32], req_wdata};
            end else if (mmio_we && (src_p0 == SRC_MTIME_HI)) begin
                mtime <= {req_wdata, mtime[31:0]};
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (mmio_we && (src_p0 == SRC_MTIMECMP_LO)) begin
                mtimecmp <= {mtimecmp[63:32], req_wdata};
            end else if (mmio_we && (src_p0 == SRC_MTIMECMP_HI)) begin
                mtimecmp <= {req_wdata, mtimecmp[31:0]};
            end

            irq_r <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        mmio_rdata = 32'h0;
        case (src_p1)
            SRC_MTIME_LO:    mmio_rdata = mtime[31:0];
            SRC_MTIME_HI:    mmio_rdata = mtime[63:32];
            SRC_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
            SRC_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
            default:         mmio_rdata = 32'h0;
        endcase
    end

    assign timer_irq = irq_r;
`else
    logic unused_cfg;

    assign unused_cfg = (TIMER_DIV > 0);
    assign mmio_rdata = 32'h0;
    assign timer_irq  = 1'b0;
`endif

    // ---- p2: RESP, rdata held for the MEM stage ----
    // stall is registered from the next state so it is high exactly in READ
    // and drops as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            stall <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        err <= (src_p0 == SRC_NONE);
                        if (!req_write) begin
                            state <= ST_READ;
                            stall <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    rdata <= (src_p1 == SRC_SRAM) ? sram_q : mmio_rdata;
                    stall <= 1'b0;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // The request still visible here is the one being consumed.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reset state, a directed vector
// table, reset during a read, timer or non-timer MMIO behaviour, and a
// randomized run against an array-based memory model.
module tb_dmem_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .TIMER_DIV  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic irq_seen = 1'b0;
    always @(posedge clk) if (timer_irq === 1'b1) irq_seen <= 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] model [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned lo, hi;
        lo = longint'(BASE);
        hi = lo + 4 * DEPTH;
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    // Called one tick after an edge with the responder idle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic exp_e, input string tag);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        check({tag, " stall_before_write"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " stall_after_write"}, {31'b0, stall}, 32'd0);
        check({tag, " err_write"}, {31'b0, err}, {31'b0, exp_e});
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e, input string tag);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = $urandom;
        @(posedge clk); #1;
        check({tag, " stall_in_read"}, {31'b0, stall}, 32'd1);
        check({tag, " err_read"}, {31'b0, err}, {31'b0, exp_e});
        @(posedge clk); #1;
        check({tag, " stall_in_resp"}, {31'b0, stall}, 32'd0);
        check({tag, " rdata"}, rdata, exp_d);
        // Request still held through the RESP edge; it must not start a new read.
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " no_reaccept"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset stall", {31'b0, stall}, 32'd0);
        check("post_reset err", {31'b0, err}, 32'd0);
        check("post_reset rdata", rdata, 32'd0);
        check("post_reset irq", {31'b0, timer_irq}, 32'd0);

        // Directed table
        vecs.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(1, 32'h0000_0000, 32'h1111_1111, 32'h0, 0));
        vecs.push_back(mk(1, 32'h0000_0004, 32'h2222_2222, 32'h0, 0));
        vecs.push_back(mk(1, 32'h0000_0008, 32'h3333_3333, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0000_0004, 32'h0, 32'h2222_2222, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0));
        vecs.push_back(mk(0, 32'h8000_0000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0));
        vecs.push_back(mk(1, 32'h0000_4000, 32'h55AA_55AA, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0));
        vecs.push_back(mk(1, 32'h0000_3FFC, 32'h0BAD_CAFE, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0000_3FFC, 32'h0, 32'h0BAD_CAFE, 0));
        vecs.push_back(mk(0, 32'h0000_4000, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 32'h0000_0008, 32'h0, 32'h3333_3333, 0));
`ifndef KASUMI_DMEM_TIMER_EN
        vecs.push_back(mk(0, 32'hFFFF_FF00, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 32'hFFFF_FF08, 32'h0000_0001, 32'h0, 1));
        vecs.push_back(mk(0, 32'hFFFF_FF08, 32'h0, 32'h0, 1));
`endif
        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, $sformatf("vec%0d", i));
            else
                do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset asserted while in READ
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        check("rst_mid stall_in_read", {31'b0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid stall_async", {31'b0, stall}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid stall_after", {31'b0, stall}, 32'd0);
        check("rst_mid rdata_after", rdata, 32'd0);
        check("rst_mid err_after", {31'b0, err}, 32'd0);
        do_read(32'h10, 32'hDEAD_BEEF, 1'b0, "rst_mid reread");

`ifdef KASUMI_DMEM_TIMER_EN
        // mtimecmp = 5, then restart mtime at 0; one increment per cycle.
        do_write(32'hFFFF_FF08, 32'd5, 1'b0, "tmr cmp_lo");
        do_write(32'hFFFF_FF0C, 32'd0, 1'b0, "tmr cmp_hi");
        do_write(32'hFFFF_FF04, 32'd0, 1'b0, "tmr mtime_hi");
        do_write(32'hFFFF_FF00, 32'd0, 1'b0, "tmr mtime_lo");
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            // After edge k, mtime sampled at that edge was k-1.
            check($sformatf("tmr irq_k%0d", k), {31'b0, timer_irq}, {31'b0, ((k - 1) >= 5)});
        end
        do_write(32'hFFFF_FF08, 32'hFFFF_FFFF, 1'b0, "tmr cmp_raise");
        @(posedge clk); #1;
        check("tmr irq_cleared", {31'b0, timer_irq}, 32'd0);
        do_read(32'hFFFF_FF08, 32'hFFFF_FFFF, 1'b0, "tmr rd_cmp_lo");
        do_read(32'hFFFF_FF0C, 32'h0, 1'b0, "tmr rd_cmp_hi");
`endif

        // Randomized run against the memory model
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            model[w] = d;
            do_write(BASE + 32'(w * 4), d, 1'b0, $sformatf("init%0d", w));
        end
        for (int n = 0; n < 150; n++) begin
            int unsigned op, idx;
            logic [31:0] a, d, exp_d;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 63);
            if (op <= 6) a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            else a = ($urandom_range(0, 1) == 0 ? 32'h0000_4000 : 32'h8000_0000) + 32'(idx * 4);
            d = $urandom;
            if (op == 9) begin
                req_valid = 1'b0;
                @(posedge clk); #1;
                check($sformatf("rnd%0d idle_stall", n), {31'b0, stall}, 32'd0);
            end else if (op <= 3 || op == 8) begin
                if (in_range(a)) model[(a - BASE) >> 2] = d;
                do_write(a, d, !in_range(a), $sformatf("rnd%0d wr", n));
            end else begin
                exp_d = in_range(a) ? model[(a - BASE) >> 2] : 32'h0;
                do_read(a, exp_d, !in_range(a), $sformatf("rnd%0d rd", n));
            end
        end

`ifndef KASUMI_DMEM_TIMER_EN
        check("notimer irq_never_high", {31'b0, irq_seen}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
